// File: rtl/store_write_buffer_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
//   Types and constants shared between the processor data port, the posted
//   write buffer and the backing-memory bus.
//
//   ADDR_W / DATA_W : address and data widths of the processor data port
//   wb_entry_t      : one buffered store, {addr, data}
//   drain_state_t   : drain FSM states (IDLE, REQ)
//   sameWord()      : word-granular address compare used for forwarding
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

    // Byte offset bits are ignored; two addresses hit when they name the
    // same 32-bit word.
    function automatic logic sameWord(input logic [ADDR_W-1:0] addrA,
                                      input logic [ADDR_W-1:0] addrB);
        return addrA[ADDR_W-1:2] == addrB[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// ---------------------------------------------------------------------------
// store_write_buffer_if
//   Bundles every non-clock/reset signal of the posted write buffer.
//
//   Processor side : cpu_we, cpu_addr, cpu_wdata -> buffer; cpu_rdata <- buffer
//   Memory read    : mem_raddr <- buffer; mem_rdata -> buffer
//   Drain bus      : bus_req, bus_addr, bus_wdata <- buffer; bus_ack -> buffer
//   Status         : full, empty, count, overflow <- buffer
//
//   slave  : the buffer itself
//   master : the environment (processor + backing memory)
// ---------------------------------------------------------------------------
interface store_write_buffer_if #(
    parameter int PTR_W = 2
);
    import cpu_mem_pkg::*;

    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;

    logic              full;
    logic              empty;
    logic [PTR_W:0]    count;
    logic              overflow;

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, mem_rdata, bus_ack,
        output cpu_rdata, mem_raddr, bus_req, bus_addr, bus_wdata,
        output full, empty, count, overflow
    );

    modport master (
        output cpu_we, cpu_addr, cpu_wdata, mem_rdata, bus_ack,
        input  cpu_rdata, mem_raddr, bus_req, bus_addr, bus_wdata,
        input  full, empty, count, overflow
    );

endinterface

// File: rtl/store_write_buffer_wb_fifo_mem.sv
// ---------------------------------------------------------------------------
// wb_fifo_mem
//   Entry storage for the posted write buffer: DEPTH registers of
//   wb_entry_t with one write port. The whole array is exposed so the top
//   can index the head entry and search every slot for load forwarding.
//
//   clk       : rising-edge clock
//   we_i      : write enable (an accepted store)
//   waddr_i   : slot written (write pointer)
//   wentry_i  : {addr, data} to store
//   entries_o : full array contents
// ---------------------------------------------------------------------------
module wb_fifo_mem
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic      [PTR_W-1:0]      waddr_i,
    input  wb_entry_t                  wentry_i,
    output wb_entry_t [DEPTH-1:0]      entries_o
);

    wb_entry_t [DEPTH-1:0] mem_q;

    // Storage has no reset: a slot only matters once the pointers say it
    // is occupied, and it is always written before that happens.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wentry_i;
        end
    end

    assign entries_o = mem_q;

endmodule

// File: rtl/store_write_buffer.sv
// ---------------------------------------------------------------------------
// store_write_buffer
//   Posted-write buffer between a single-cycle processor data port and a
//   slow req/ack backing memory. Stores land in a DEPTH-entry FIFO in one
//   cycle and drain to the bus in order. Loads read memory combinationally,
//   but a load that hits a buffered store gets the youngest buffered data so
//   the processor always observes program order. The processor cannot be
//   stalled, so capacity is only reported through the status outputs.
//
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   wb    : store_write_buffer_if.slave (processor port, memory read port,
//           drain bus, status)
// ---------------------------------------------------------------------------
module store_write_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  wb
);

    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  overflow_q, overflow_d;
    drain_state_t          state_q, state_d;

    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  busReq;
    wb_entry_t             newEntry;
    wb_entry_t [DEPTH-1:0] entries;

    logic                  fwdHit;
    logic [DATA_W-1:0]     fwdData;
    logic [PTR_W-1:0]      slotIdx;

    // A full buffer still accepts a store when the head leaves in the same
    // cycle, so nothing is lost while the bus keeps up.
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign pop      = busReq & wb.bus_ack;
    assign push     = wb.cpu_we & (~full | pop);
    assign newEntry = '{addr: wb.cpu_addr, data: wb.cpu_wdata};

    wb_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo_mem (
        .clk       (clk),
        .we_i      (push),
        .waddr_i   (wrPtr_q),
        .wentry_i  (newEntry),
        .entries_o (entries)
    );

    // State register. Reset drops bus_req immediately and discards every
    // pending entry by clearing the pointers and the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    // Pointer, occupancy and sticky overflow update. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        overflow_d = overflow_q | (wb.cpu_we & full & ~pop);
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // Drain FSM. IDLE waits for the buffer to become non-empty; REQ holds
    // bus_req and presents the head entry until the last entry is acked
    // with no store arriving to replace it.
    always_comb begin
        state_d = state_q;
        busReq  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_d != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                busReq = 1'b1;
                if (pop && (count_q == (PTR_W+1)'(1)) && !push) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load forwarding. Walk the occupied slots from oldest to youngest so
    // the last match seen is the youngest store to that word. The head slot
    // still counts while it is being acked, since the write has not reached
    // memory before the clock edge.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        slotIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slotIdx = rdPtr_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) &&
                sameWord(entries[slotIdx].addr, wb.cpu_addr)) begin
                fwdHit  = 1'b1;
                fwdData = entries[slotIdx].data;
            end
        end
    end

    // Output assembly. The bus fields follow the head slot; they only change
    // when rd_ptr moves, i.e. the cycle after an ack.
    assign wb.cpu_rdata = (!wb.cpu_we && fwdHit) ? fwdData : wb.mem_rdata;
    assign wb.mem_raddr = wb.cpu_addr;
    assign wb.bus_req   = busReq;
    assign wb.bus_addr  = entries[rdPtr_q].addr;
    assign wb.bus_wdata = entries[rdPtr_q].data;
    assign wb.full      = full;
    assign wb.empty     = (count_q == '0);
    assign wb.count     = count_q;
    assign wb.overflow  = overflow_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_write_buffer
//   Scoreboard bench for store_write_buffer. Accepted stores are queued as
//   expected bus writes when driven; every bus handshake pops and compares.
//   A small occupancy model tracks count/overflow independently.
// ---------------------------------------------------------------------------
module tb_store_write_buffer;
    import cpu_mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam logic [DATA_W-1:0] MEM_PATTERN = 32'hDEAD_BEEF;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int vectorCount     = 0;
    int miscompareCount = 0;

    wb_entry_t expQ[$];
    int        modelCount    = 0;
    logic      modelOverflow = 1'b0;

    store_write_buffer_if #(.PTR_W(PTR_W)) wbIf();

    store_write_buffer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wbIf.slave)
    );

    always #5 clk = ~clk;

    // One comparison: count it and report a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Bus monitor: inputs change just after the rising edge, so at the
    // falling edge a req&ack pair is exactly the handshake the next edge
    // will complete.
    always @(negedge clk) begin
        wb_entry_t expEntry;
        if (reset === 1'b1 && wbIf.bus_req === 1'b1 && wbIf.bus_ack === 1'b1) begin
            checkOutput("stray write", 64'(expQ.size() == 0), 64'd0);
            if (expQ.size() > 0) begin
                expEntry = expQ.pop_front();
                checkOutput("drain addr", 64'(wbIf.bus_addr), 64'(expEntry.addr));
                checkOutput("drain data", 64'(wbIf.bus_wdata), 64'(expEntry.data));
            end
        end
    end

    // Drive one cycle of stimulus, update the model and scoreboard, then
    // check the status outputs just after the edge.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input logic ack);
        logic      modelPop;
        logic      modelPush;
        wb_entry_t entry;
        wbIf.cpu_we    = we;
        wbIf.cpu_addr  = addr;
        wbIf.cpu_wdata = data;
        wbIf.bus_ack   = ack;
        modelPop  = (modelCount > 0) && ack;
        modelPush = we && ((modelCount < DEPTH) || modelPop);
        if (we && !modelPush) modelOverflow = 1'b1;
        if (modelPush) begin
            entry.addr = addr;
            entry.data = data;
            expQ.push_back(entry);
        end
        modelCount = modelCount + int'(modelPush) - int'(modelPop);
        @(posedge clk);
        #1;
        checkOutput("count",    64'(wbIf.count),    64'(modelCount));
        checkOutput("bus_req",  64'(wbIf.bus_req),  64'(modelCount > 0));
        checkOutput("empty",    64'(wbIf.empty),    64'(modelCount == 0));
        checkOutput("full",     64'(wbIf.full),     64'(modelCount == DEPTH));
        checkOutput("overflow", 64'(wbIf.overflow), 64'(modelOverflow));
    endtask

    // Combinational load check without advancing the clock.
    task automatic loadCheck(input string tag, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] expected);
        wbIf.cpu_we   = 1'b0;
        wbIf.cpu_addr = addr;
        #1;
        checkOutput(tag, 64'(wbIf.cpu_rdata), 64'(expected));
        checkOutput("mem_raddr", 64'(wbIf.mem_raddr), 64'(addr));
    endtask

    // Mid-cycle reset pulse: outputs must clear before any clock edge.
    task automatic resetPulse();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst bus_req",  64'(wbIf.bus_req),  64'd0);
        checkOutput("rst count",    64'(wbIf.count),    64'd0);
        checkOutput("rst empty",    64'(wbIf.empty),    64'd1);
        checkOutput("rst overflow", 64'(wbIf.overflow), 64'd0);
        expQ.delete();
        modelCount    = 0;
        modelOverflow = 1'b0;
        wbIf.cpu_we   = 1'b0;
        wbIf.bus_ack  = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    initial begin
        wbIf.cpu_we    = 1'b0;
        wbIf.cpu_addr  = '0;
        wbIf.cpu_wdata = '0;
        wbIf.bus_ack   = 1'b0;
        wbIf.mem_rdata = MEM_PATTERN;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init count",    64'(wbIf.count),    64'd0);
        checkOutput("init empty",    64'(wbIf.empty),    64'd1);
        checkOutput("init full",     64'(wbIf.full),     64'd0);
        checkOutput("init bus_req",  64'(wbIf.bus_req),  64'd0);
        checkOutput("init overflow", 64'(wbIf.overflow), 64'd0);
        reset = 1'b1;

        // Single store, one-cycle latency to bus_req, then ack
        applyStimulus(1'b1, 32'h10, 32'hAA, 1'b0);
        checkOutput("t1 bus_addr",  64'(wbIf.bus_addr),  64'h10);
        checkOutput("t1 bus_wdata", 64'(wbIf.bus_wdata), 64'hAA);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

        // Forwarding of the youngest store, word granularity
        applyStimulus(1'b1, 32'h20, 32'h1, 1'b0);
        applyStimulus(1'b1, 32'h20, 32'h2, 1'b0);
        loadCheck("t2 fwd youngest", 32'h20, 32'h2);
        loadCheck("t2 fwd same word", 32'h23, 32'h2);
        loadCheck("t2 fwd miss", 32'h24, MEM_PATTERN);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        loadCheck("t2 fwd popping", 32'h20, 32'h2);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        loadCheck("t2 after drain", 32'h20, MEM_PATTERN);

        // Overflow: fifth store dropped, drain order preserved
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'(i), 1'b0);
        end
        checkOutput("t3 overflow", 64'(wbIf.overflow), 64'd1);
        checkOutput("t3 count",    64'(wbIf.count),    64'd4);
        repeat (4) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        resetPulse();

        // Full with simultaneous pop: store accepted, drains last
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'h50 + 32'(i), 1'b0);
        end
        applyStimulus(1'b1, 32'h40, 32'h7, 1'b1);
        checkOutput("t4 count",    64'(wbIf.count),    64'd4);
        checkOutput("t4 overflow", 64'(wbIf.overflow), 64'd0);
        repeat (4) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

        // Streaming with ack held: pointers wrap, occupancy stays low
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1);
            checkOutput("t5 count<=1", 64'(wbIf.count <= 3'd1), 64'd1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

        // Reset mid-handshake discards pending entries
        applyStimulus(1'b1, 32'h500, 32'h11, 1'b0);
        applyStimulus(1'b1, 32'h504, 32'h22, 1'b0);
        resetPulse();
        repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h600, 32'h33, 1'b0);
        checkOutput("t6 bus_addr", 64'(wbIf.bus_addr), 64'h600);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

        #10;
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
